// File: rtl/paint_mix_sequencer_if.sv
// Bundle of the paint_mix_sequencer control signals, shared by the keyboard
// front end, stepper enables and car controller on one side and the
// sequencer on the other.
//
// Handshake semantics: there is no valid/ready backpressure on this bundle.
// confirm, step_tick and car_done are single-cycle event pulses in the clk
// domain, each acting as a "valid" with an implicit always-ready consumer.
// The sequencer samples them only in the states where they have meaning and
// silently drops them otherwise. car_start and reject are single-cycle
// pulses in the other direction. The enables, busy, round and done are
// levels that follow the sequencer state.
interface paint_mix_sequencer_if;
  logic [3:0] color_id;
  logic       confirm;
  logic       step_tick;
  logic       car_done;
  logic       en_red;
  logic       en_yellow;
  logic       en_blue;
  logic       car_start;
  logic       busy;
  logic [1:0] round;
  logic       done;
  logic       reject;

  // Master side: the surrounding station (keyboard, motors, car).
  modport master (
    output color_id,
    output confirm,
    output step_tick,
    output car_done,
    input  en_red,
    input  en_yellow,
    input  en_blue,
    input  car_start,
    input  busy,
    input  round,
    input  done,
    input  reject
  );

  // Slave side: the sequencer itself.
  modport slave (
    input  color_id,
    input  confirm,
    input  step_tick,
    input  car_done,
    output en_red,
    output en_yellow,
    output en_blue,
    output car_start,
    output busy,
    output round,
    output done,
    output reject
  );
endinterface

// File: rtl/paint_mix_sequencer.sv
// Round-based paint mixing sequencer. A confirmed color selects a red/yellow/
// blue recipe; the three dispensing motors run one after another for
// units * UNIT_STEPS steps each, then the delivery car is launched and the
// sequencer waits for it. ROUNDS such rounds form one job, after which the
// block parks in DONE until the operator confirms again.
module paint_mix_sequencer #(
  parameter int UNIT_STEPS = 64,
  parameter int ROUNDS     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  paint_mix_sequencer_if.slave  bus,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RED       = 3'd1,
    YELLOW    = 3'd2,
    BLUE      = 3'd3,
    CAR_START = 3'd4,
    CAR_WAIT  = 3'd5,
    DONE      = 3'd6
  } state_t;

  // Step count per recipe unit, at the width of the step counter. The legal
  // UNIT_STEPS range keeps 3 * UNIT_STEPS within 16 bits.
  localparam logic [15:0] UNIT_STEPS_W = 16'(UNIT_STEPS);
  localparam logic [1:0]  LAST_ROUND   = 2'(ROUNDS - 1);

  // Recipe packed as {red, yellow, blue}, two bits of units each.
  function automatic logic [5:0] recipe_of(input logic [3:0] id);
    logic [5:0] rec;
    rec = 6'd0;
    case (id)
      4'd0: rec = {2'd3, 2'd0, 2'd0};  // red
      4'd1: rec = {2'd0, 2'd3, 2'd0};  // yellow
      4'd2: rec = {2'd0, 2'd0, 2'd3};  // blue
      4'd3: rec = {2'd1, 2'd1, 2'd0};  // orange
      4'd4: rec = {2'd0, 2'd1, 2'd1};  // green
      4'd5: rec = {2'd1, 2'd0, 2'd1};  // purple
      4'd6: rec = {2'd1, 2'd1, 2'd1};  // brown
      default: rec = 6'd0;             // clear, and ids 8..15 (never latched)
    endcase
    return rec;
  endfunction

  // Next phase after 'cur' (IDLE meaning "before any phase"), skipping every
  // colour whose unit count is zero; falls through to the car launch.
  function automatic state_t after_phase(input state_t cur, input logic [5:0] rec);
    state_t nxt;
    if (cur == IDLE && rec[5:4] != 2'd0) begin
      nxt = RED;
    end else if ((cur == IDLE || cur == RED) && rec[3:2] != 2'd0) begin
      nxt = YELLOW;
    end else if (cur != BLUE && rec[1:0] != 2'd0) begin
      nxt = BLUE;
    end else begin
      nxt = CAR_START;
    end
    return nxt;
  endfunction

  state_t      state;
  state_t      state_next;
  logic [15:0] step_cnt;
  logic [15:0] step_cnt_next;
  logic [15:0] step_cnt_inc;
  logic [15:0] target;
  logic [1:0]  phase_units;
  logic [1:0]  round_q;
  logic [1:0]  round_next;
  logic [5:0]  recipe_q;
  logic [5:0]  recipe_next;
  logic [5:0]  recipe_sel;
  logic        color_valid;
  logic        reject_q;
  logic        reject_next;

  assign recipe_sel   = recipe_of(bus.color_id);
  assign color_valid  = ~bus.color_id[3];
  assign step_cnt_inc = step_cnt + 16'd1;
  assign target       = {14'd0, phase_units} * UNIT_STEPS_W;

  // Unit count of the motor phase currently running (zero outside phases).
  always_comb begin
    phase_units = 2'd0;
    case (state)
      RED:     phase_units = recipe_q[5:4];
      YELLOW:  phase_units = recipe_q[3:2];
      BLUE:    phase_units = recipe_q[1:0];
      default: phase_units = 2'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the next values of the step counter, round index,
  // latched recipe and reject pulse.
  always_comb begin
    state_next    = state;
    step_cnt_next = step_cnt;
    round_next    = round_q;
    recipe_next   = recipe_q;
    reject_next   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.confirm) begin
          if (color_valid) begin
            recipe_next = recipe_sel;
            state_next  = after_phase(IDLE, recipe_sel);
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      RED, YELLOW, BLUE: begin
        if (bus.step_tick) begin
          if (step_cnt_inc == target) begin
            step_cnt_next = 16'd0;
            state_next    = after_phase(state, recipe_q);
          end else begin
            step_cnt_next = step_cnt_inc;
          end
        end
      end
      CAR_START: begin
        state_next = CAR_WAIT;
      end
      CAR_WAIT: begin
        if (bus.car_done) begin
          if (round_q == LAST_ROUND) begin
            state_next = DONE;
          end else begin
            round_next = round_q + 2'd1;
            state_next = IDLE;
          end
        end
      end
      DONE: begin
        // Acknowledge only: the colour code is not looked at here.
        if (bus.confirm) begin
          round_next = 2'd0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: step counter, round index, recipe and reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= 16'd0;
      round_q  <= 2'd0;
      recipe_q <= 6'd0;
      reject_q <= 1'b0;
    end else begin
      step_cnt <= step_cnt_next;
      round_q  <= round_next;
      recipe_q <= recipe_next;
      reject_q <= reject_next;
    end
  end

  // Moore output decode from the registered state; at most one enable is
  // ever high because each enable belongs to exactly one state.
  always_comb begin
    bus.en_red    = (state == RED);
    bus.en_yellow = (state == YELLOW);
    bus.en_blue   = (state == BLUE);
    bus.car_start = (state == CAR_START);
    bus.busy      = (state != IDLE) && (state != DONE);
    bus.done      = (state == DONE);
    bus.round     = round_q;
    bus.reject    = reject_q;
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_paint_mix_sequencer.sv
// Testbench for paint_mix_sequencer. A queue-based reference model lists the
// segments a job walks through (colour phases with their remaining tick
// counts, car launch, car wait) and is advanced by the same inputs driven
// into the DUT; the DUT outputs are compared against it every cycle.
module tb_paint_mix_sequencer;
  localparam int UNIT_STEPS = 4;
  localparam int ROUNDS     = 3;

  // Segment kinds held in exp_q.
  localparam logic [2:0] K_RED  = 3'd0;
  localparam logic [2:0] K_YEL  = 3'd1;
  localparam logic [2:0] K_BLU  = 3'd2;
  localparam logic [2:0] K_CS   = 3'd3;
  localparam logic [2:0] K_WAIT = 3'd4;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  paint_mix_sequencer_if bus ();

  paint_mix_sequencer #(
    .UNIT_STEPS(UNIT_STEPS),
    .ROUNDS(ROUNDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [2:0] exp_q[$];
  int         left_q[$];
  int         exp_round;
  bit         exp_done;
  bit         exp_reject;
  int recipe_units [0:7][0:2] = '{
    '{3, 0, 0}, '{0, 3, 0}, '{0, 0, 3}, '{1, 1, 0},
    '{0, 1, 1}, '{1, 0, 1}, '{1, 1, 1}, '{0, 0, 0}
  };

  function automatic void model_apply(input logic r, input logic conf, input logic [3:0] id,
                                      input logic tick, input logic cdone);
    exp_reject = 1'b0;
    if (r) begin
      exp_q.delete();
      left_q.delete();
      exp_round = 0;
      exp_done  = 1'b0;
      return;
    end
    if (exp_done) begin
      if (conf) begin
        exp_done  = 1'b0;
        exp_round = 0;
      end
    end else if (exp_q.size() == 0) begin
      if (conf) begin
        if (id < 4'd8) begin
          for (int c = 0; c < 3; c++) begin
            if (recipe_units[id][c] > 0) begin
              exp_q.push_back(3'(c));
              left_q.push_back(recipe_units[id][c] * UNIT_STEPS);
            end
          end
          exp_q.push_back(K_CS);
          left_q.push_back(1);
          exp_q.push_back(K_WAIT);
          left_q.push_back(0);
        end else begin
          exp_reject = 1'b1;
        end
      end
    end else begin
      case (exp_q[0])
        K_CS: begin
          void'(exp_q.pop_front());
          void'(left_q.pop_front());
        end
        K_WAIT: begin
          if (cdone) begin
            void'(exp_q.pop_front());
            void'(left_q.pop_front());
            if (exp_round == ROUNDS - 1) exp_done = 1'b1;
            else exp_round++;
          end
        end
        default: begin
          if (tick) begin
            left_q[0] = left_q[0] - 1;
            if (left_q[0] == 0) begin
              void'(exp_q.pop_front());
              void'(left_q.pop_front());
            end
          end
        end
      endcase
    end
  endfunction

  // {en_red, en_yellow, en_blue, car_start, busy, done, reject, round}
  function automatic logic [8:0] exp_vec();
    int k;
    k = (exp_q.size() > 0) ? int'(exp_q[0]) : 7;
    return {k == 0, k == 1, k == 2, k == 3, exp_q.size() > 0, exp_done, exp_reject,
            2'(exp_round)};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {bus.en_red, bus.en_yellow, bus.en_blue, bus.car_start, bus.busy, bus.done,
            bus.reject, bus.round};
  endfunction

  function automatic bit model_in_wait();
    return (exp_q.size() > 0) && (exp_q[0] == K_WAIT);
  endfunction

  // Driver: called at a negedge, applies inputs for the next posedge,
  // advances the model and returns at the following negedge.
  task automatic tick_cycle(input logic r, input logic conf, input logic [3:0] id,
                            input logic tick, input logic cdone);
    rst           = r;
    bus.confirm   = conf;
    bus.color_id  = id;
    bus.step_tick = tick;
    bus.car_done  = cdone;
    model_apply(r, conf, id, tick, cdone);
    @(negedge clk);
    rst           = 1'b0;
    bus.confirm   = 1'b0;
    bus.step_tick = 1'b0;
    bus.car_done  = 1'b0;
  endtask

  task automatic test_reset();
    tick_cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", obs_vec(), 9'd0);
    end
  endtask

  task automatic test_red_regular();
    int red_ticks = 0;
    int cs_cycles = 0;
    int wait_cnt  = 0;
    tick_cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_cycle(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    checks++;
    if (bus.en_red !== 1'b1) begin
      failures++;
      $display("FAIL red_first_cycle got=%b exp=1", bus.en_red);
    end
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      logic t;
      logic cd;
      t  = (c % 4 == 3);
      cd = 1'b0;
      if (model_in_wait()) begin
        wait_cnt++;
        cd = (wait_cnt >= 3);
      end
      if (bus.en_red && t) red_ticks++;
      if (bus.car_start) cs_cycles++;
      tick_cycle(1'b0, 1'b0, 4'd0, t, cd);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL red_cycle c=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL red_timeout got=%0d exp=0 segments left", exp_q.size());
    end
    checks++;
    if (red_ticks != 3 * UNIT_STEPS || cs_cycles != 1) begin
      failures++;
      $display("FAIL red_counts got=%0d/%0d exp=%0d/1", red_ticks, cs_cycles, 3 * UNIT_STEPS);
    end
    checks++;
    if (bus.round !== 2'd1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL red_round got=%0d/%b exp=1/0", bus.round, bus.busy);
    end
  endtask

  task automatic test_brown_phases();
    int ticks [0:2] = '{0, 0, 0};
    int order_q[$];
    int gaps = 0;
    logic [2:0] prev_en = 3'b000;
    logic [2:0] cur_en;
    tick_cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_cycle(1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      logic t;
      cur_en = {bus.en_red, bus.en_yellow, bus.en_blue};
      checks++;
      if ($countones(cur_en) > 1) begin
        failures++;
        $display("FAIL brown_onehot c=%0d got=%b", c, cur_en);
      end
      if (prev_en != 3'b000 && cur_en == 3'b000 && !bus.car_start) gaps++;
      if (cur_en != 3'b000 && cur_en != prev_en)
        order_q.push_back(cur_en[2] ? 0 : (cur_en[1] ? 1 : 2));
      prev_en = cur_en;
      t = ($urandom_range(0, 2) == 0);
      if (t && cur_en[2]) ticks[0]++;
      if (t && cur_en[1]) ticks[1]++;
      if (t && cur_en[0]) ticks[2]++;
      tick_cycle(1'b0, 1'b0, 4'd0, t, model_in_wait() && ($urandom_range(0, 3) == 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL brown_cycle c=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL brown_timeout got=%0d exp=0 segments left", exp_q.size());
    end
    checks++;
    if (ticks[0] != UNIT_STEPS || ticks[1] != UNIT_STEPS || ticks[2] != UNIT_STEPS) begin
      failures++;
      $display("FAIL brown_ticks got=%0d,%0d,%0d exp=%0d each", ticks[0], ticks[1], ticks[2],
               UNIT_STEPS);
    end
    checks++;
    if (order_q.size() != 3 || order_q[0] != 0 || order_q[1] != 1 || order_q[2] != 2 ||
        gaps != 0) begin
      failures++;
      $display("FAIL brown_order got=%p gaps=%0d exp='{0,1,2} gaps=0", order_q, gaps);
    end
  endtask

  task automatic test_clear();
    bit any_en = 1'b0;
    tick_cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_cycle(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    checks++;
    if (bus.car_start !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_car_start got=%b/%b exp=1/1", bus.car_start, bus.busy);
    end
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      if (bus.en_red || bus.en_yellow || bus.en_blue) any_en = 1'b1;
      tick_cycle(1'b0, 1'b0, 4'd0, 1'b1, model_in_wait() && c >= 2);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL clear_cycle c=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (any_en || exp_q.size() != 0) begin
      failures++;
      $display("FAIL clear_no_enable got=%b/%0d exp=0/0", any_en, exp_q.size());
    end
  endtask

  task automatic test_invalid();
    logic [3:0] ids [0:1];
    ids[0] = 4'd9;
    ids[1] = 4'($urandom_range(8, 15));
    tick_cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick_cycle(1'b0, 1'b1, ids[i], 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || bus.reject !== 1'b1 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL invalid_reject id=%0d got=%b exp=%b", ids[i], obs_vec(), exp_vec());
      end
      tick_cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec() || bus.reject !== 1'b0) begin
        failures++;
        $display("FAIL invalid_single_pulse id=%0d got=%b exp=%b", ids[i], obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_three_rounds();
    logic [3:0] ids [0:2];
    ids[0] = 4'd0;
    ids[1] = 4'd4;
    ids[2] = 4'd5;
    tick_cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int r = 0; r < ROUNDS; r++) begin
      tick_cycle(1'b0, 1'b1, ids[r], 1'b0, 1'b0);
      for (int c = 0; c < 600 && exp_q.size() > 0; c++) begin
        tick_cycle(1'b0, ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL rounds_cycle r=%0d c=%0d got=%b exp=%b", r, c, obs_vec(), exp_vec());
        end
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL rounds_timeout r=%0d got=%0d exp=0 segments left", r, exp_q.size());
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.round !== 2'(ROUNDS - 1) || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rounds_done got=%b/%0d/%b exp=1/%0d/0", bus.done, bus.round, bus.busy,
               ROUNDS - 1);
    end
    for (int c = 0; c < 8; c++) begin
      tick_cycle(1'b0, 1'b0, 4'd0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL done_hold c=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      end
    end
    tick_cycle(1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 9'd0 || exp_vec() !== 9'd0) begin
      failures++;
      $display("FAIL done_confirm got=%b exp=%b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    int seen_ticks = 0;
    int yel_ticks  = 0;
    bit red_seen   = 1'b0;
    tick_cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick_cycle(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    for (int c = 0; c < 40 && seen_ticks < 5; c++) begin
      logic t;
      t = (c % 2 == 1);
      if (t) seen_ticks++;
      tick_cycle(1'b0, 1'b0, 4'd0, t, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL midrst_pre c=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      end
    end
    tick_cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    checks++;
    if (obs_vec() !== 9'd0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b exp=%b", obs_vec(), 9'd0);
    end
    tick_cycle(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      logic t;
      t = ($urandom_range(0, 1) == 1);
      if (bus.en_red) red_seen = 1'b1;
      if (t && bus.en_yellow) yel_ticks++;
      tick_cycle(1'b0, 1'b0, 4'd0, t, model_in_wait() && ($urandom_range(0, 2) == 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL midrst_post c=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (yel_ticks != 3 * UNIT_STEPS || red_seen || exp_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_yellow got=%0d/%b/%0d exp=%0d/0/0", yel_ticks, red_seen,
               exp_q.size(), 3 * UNIT_STEPS);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.color_id  = 4'd0;
    bus.confirm   = 1'b0;
    bus.step_tick = 1'b0;
    bus.car_done  = 1'b0;
    exp_round     = 0;
    exp_done      = 1'b0;
    exp_reject    = 1'b0;
    @(negedge clk);
    test_reset();
    test_red_regular();
    test_brown_phases();
    test_clear();
    test_invalid();
    test_three_rounds();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
